// File: rtl/conv_frame_loader_pkg.sv
// Shared sizing for the 8x8 convolution array and its frame loader.
package conv_frame_loader_pkg;

    localparam int PIX_W     = 2;
    localparam int IMG_DIM   = 8;
    localparam int K_DIM     = 3;

    localparam int NPIX      = IMG_DIM * IMG_DIM;
    localparam int NWGT      = K_DIM * K_DIM;
    localparam int IMG_BITS  = NPIX * PIX_W;
    localparam int FILT_BITS = NWGT * PIX_W;

    localparam int PCNT_W    = $clog2(NPIX);
    localparam int WCNT_W    = $clog2(NWGT);
    localparam int CNT_W     = 8;

endpackage

// File: rtl/conv_frame_loader_if.sv
// Pixel stream, weight stream and frame output of the frame loader.
//
// Handshake rule for all three channels (pix, wgt, frame): a beat moves on a
// rising clk edge where valid && ready are both 1. The sender holds data
// stable and keeps valid asserted until that edge; ready may rise or fall
// independently of valid.
interface conv_frame_loader_if;
    import conv_frame_loader_pkg::*;

    logic                 pix_valid;
    logic [PIX_W-1:0]     pix_data;
    logic                 pix_ready;

    logic                 wgt_valid;
    logic [PIX_W-1:0]     wgt_data;
    logic                 wgt_ready;

    logic                 frame_valid;
    logic                 frame_ready;
    logic [IMG_BITS-1:0]  img;
    logic [FILT_BITS-1:0] filter;
    logic [CNT_W-1:0]     frame_count;

    // Stream source / frame consumer side.
    modport master (
        output pix_valid, pix_data, wgt_valid, wgt_data, frame_ready,
        input  pix_ready, wgt_ready, frame_valid, img, filter, frame_count
    );

    // Loader side.
    modport slave (
        input  pix_valid, pix_data, wgt_valid, wgt_data, frame_ready,
        output pix_ready, wgt_ready, frame_valid, img, filter, frame_count
    );

endinterface

// File: rtl/conv_slot_writer.sv
// Flat register of SLOTS 2-bit entries; one entry is written per enabled edge.
module conv_slot_writer
    import conv_frame_loader_pkg::*;
#(
    parameter int SLOTS = NPIX,
    parameter int IDX_W = PCNT_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en_i,
    input  logic [IDX_W-1:0]       idx_i,
    input  logic [PIX_W-1:0]       data_i,
    output logic [SLOTS*PIX_W-1:0] flat_o
);

    logic [SLOTS*PIX_W-1:0] flat_q;

    // Decode the index against every slot so each write is a constant part-select.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flat_q <= '0;
        end else begin
            for (int s = 0; s < SLOTS; s++) begin
                if (en_i && (idx_i == IDX_W'(s))) begin
                    flat_q[s*PIX_W +: PIX_W] <= data_i;
                end
            end
        end
    end

    assign flat_o = flat_q;

endmodule

// File: rtl/conv_frame_loader.sv
// Assembles raster pixel/weight streams into double-buffered frames for the
// convolution array: one frame fills while the previous one is presented.
module conv_frame_loader
    import conv_frame_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    conv_frame_loader_if.slave bus
);

    logic [PCNT_W-1:0]    pcnt_q, pcnt_d;
    logic                 asm_full_q, asm_full_d;
    logic [WCNT_W-1:0]    wcnt_q, wcnt_d;
    logic                 frame_valid_q, frame_valid_d;
    logic [CNT_W-1:0]     frame_count_q, frame_count_d;
    logic [IMG_BITS-1:0]  img_q;
    logic [FILT_BITS-1:0] filter_q;

    logic [IMG_BITS-1:0]  asm_buf;
    logic [FILT_BITS-1:0] wgt_buf;

    logic pix_acc;
    logic wgt_acc;
    logic xfer;

    // A full assembly buffer moves to the output when the output is empty or
    // being consumed on this same edge.
    assign pix_acc = bus.pix_valid && !asm_full_q;
    assign wgt_acc = bus.wgt_valid;
    assign xfer    = asm_full_q && (!frame_valid_q || bus.frame_ready);

    conv_slot_writer #(.SLOTS(NPIX), .IDX_W(PCNT_W)) u_asm_writer (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (pix_acc),
        .idx_i  (pcnt_q),
        .data_i (bus.pix_data),
        .flat_o (asm_buf)
    );

    conv_slot_writer #(.SLOTS(NWGT), .IDX_W(WCNT_W)) u_wgt_writer (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (wgt_acc),
        .idx_i  (wcnt_q),
        .data_i (bus.wgt_data),
        .flat_o (wgt_buf)
    );

    // Next-state for counters, the full flag and the output handshake.
    always_comb begin
        pcnt_d        = pcnt_q;
        asm_full_d    = asm_full_q;
        wcnt_d        = wcnt_q;
        frame_valid_d = frame_valid_q;
        frame_count_d = frame_count_q;

        if (pix_acc) begin
            if (pcnt_q == PCNT_W'(NPIX - 1)) begin
                pcnt_d     = '0;
                asm_full_d = 1'b1;
            end else begin
                pcnt_d = pcnt_q + 1'b1;
            end
        end

        if (wgt_acc) begin
            wcnt_d = (wcnt_q == WCNT_W'(NWGT - 1)) ? '0 : wcnt_q + 1'b1;
        end

        // pix_acc and xfer are mutually exclusive (opposite asm_full_q).
        if (xfer) begin
            asm_full_d    = 1'b0;
            frame_valid_d = 1'b1;
            frame_count_d = frame_count_q + 1'b1;
        end else if (frame_valid_q && bus.frame_ready) begin
            frame_valid_d = 1'b0;
        end
    end

    // Control state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt_q        <= '0;
            asm_full_q    <= 1'b0;
            wcnt_q        <= '0;
            frame_valid_q <= 1'b0;
            frame_count_q <= '0;
        end else begin
            pcnt_q        <= pcnt_d;
            asm_full_q    <= asm_full_d;
            wcnt_q        <= wcnt_d;
            frame_valid_q <= frame_valid_d;
            frame_count_q <= frame_count_d;
        end
    end

    // Output frame: captured only on transfer, so it is stable while held.
    // The filter takes the staging value from before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            img_q    <= '0;
            filter_q <= '0;
        end else if (xfer) begin
            img_q    <= asm_buf;
            filter_q <= wgt_buf;
        end
    end

    assign bus.pix_ready   = !asm_full_q;
    assign bus.wgt_ready   = 1'b1;
    assign bus.frame_valid = frame_valid_q;
    assign bus.img         = img_q;
    assign bus.filter      = filter_q;
    assign bus.frame_count = frame_count_q;

endmodule

// File: tb/tb_conv_frame_loader.sv
// Directed bench for conv_frame_loader: frame assembly, weight capture
// timing, backpressure, mid-frame reset and frame counter wrap.
module tb_conv_frame_loader;
    import conv_frame_loader_pkg::*;

    localparam logic [127:0] IMG_MODE0 = {16{8'hE4}};
    localparam logic [127:0] IMG_MODE1 = {4{32'hFFAA5500}};

    logic clk = 1'b0;
    logic rst_n;

    int vectors     = 0;
    int miscompares = 0;
    int stalls      = 0;
    bit gap_en      = 1'b0;

    logic [1:0]   pix_mem [NPIX];
    logic [127:0] exp_a;

    conv_frame_loader_if bus ();

    conv_frame_loader dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Clock and watchdog.
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Offer one pixel and hold it until accepted; counts cycles spent stalled.
    task automatic send_pixel(input logic [1:0] v);
        int  waited;
        int  g;
        logic acc;
        if (gap_en) begin
            g = $urandom_range(0, 3);
            bus.pix_valid = 1'b0;
            bus.pix_data  = 2'($urandom_range(0, 3));
            repeat (g) tick();
        end
        bus.pix_valid = 1'b1;
        bus.pix_data  = v;
        waited = 0;
        acc    = 1'b0;
        while (!acc && waited < 200) begin
            acc = bus.pix_ready;
            tick();
            if (!acc) waited++;
        end
        stalls += waited;
        bus.pix_valid = 1'b0;
        if (!acc) check("pix_accept_timeout", {127'd0, acc}, 128'd1);
    endtask

    task automatic send_range(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) send_pixel(pix_mem[i]);
    endtask

    task automatic load_weight(input logic [1:0] v);
        bus.wgt_valid = 1'b1;
        bus.wgt_data  = v;
        tick();
        bus.wgt_valid = 1'b0;
    endtask

    // mode 0: index mod 4; mode 1: (index/4) mod 4; otherwise random.
    task automatic gen_frame(input int mode);
        for (int i = 0; i < NPIX; i++) begin
            case (mode)
                0:       pix_mem[i] = 2'(i % 4);
                1:       pix_mem[i] = 2'((i / 4) % 4);
                default: pix_mem[i] = 2'($urandom_range(0, 3));
            endcase
        end
    endtask

    function automatic logic [127:0] model_img();
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < NPIX; i++) r[2*i +: 2] = pix_mem[i];
        return r;
    endfunction

    initial begin
        bus.pix_valid   = 1'b0;
        bus.pix_data    = 2'd0;
        bus.wgt_valid   = 1'b0;
        bus.wgt_data    = 2'd0;
        bus.frame_ready = 1'b0;
        rst_n           = 1'b0;
        repeat (2) tick();

        // Reset values.
        check("rst_pix_ready",   bus.pix_ready,   1);
        check("rst_wgt_ready",   bus.wgt_ready,   1);
        check("rst_frame_valid", bus.frame_valid, 0);
        check("rst_img",         bus.img,         0);
        check("rst_filter",      bus.filter,      0);
        check("rst_frame_count", bus.frame_count, 0);
        rst_n = 1'b1;
        tick();

        // First frame, downstream not ready.
        load_weight(2'd1); load_weight(2'd2); load_weight(2'd3);
        load_weight(2'd0); load_weight(2'd1); load_weight(2'd2);
        load_weight(2'd3); load_weight(2'd0); load_weight(2'd1);
        check("filter_before_xfer", bus.filter, 0);
        gen_frame(0);
        send_range(0, 63);
        check("f1_valid_at_last_pix", bus.frame_valid, 0);
        check("f1_pix_ready_full",    bus.pix_ready,   0);
        tick();
        check("f1_valid",     bus.frame_valid, 1);
        check("f1_img",       bus.img,         IMG_MODE0);
        check("f1_filter",    bus.filter,      18'h13939);
        check("f1_count",     bus.frame_count, 1);
        check("f1_pix_ready", bus.pix_ready,   1);

        // Backpressure: second frame completes while the first is held.
        gen_frame(1);
        send_range(0, 63);
        repeat (5) tick();
        check("bp_pix_ready", bus.pix_ready,   0);
        check("bp_img_held",  bus.img,         IMG_MODE0);
        check("bp_valid",     bus.frame_valid, 1);
        check("bp_count",     bus.frame_count, 1);
        bus.frame_ready = 1'b1;
        tick();
        bus.frame_ready = 1'b0;
        check("bp_img_new",     bus.img,         IMG_MODE1);
        check("bp_valid_kept",  bus.frame_valid, 1);
        check("bp_count_new",   bus.frame_count, 2);
        check("bp_pix_ready_1", bus.pix_ready,   1);
        check("bp_filter",      bus.filter,      18'h13939);

        // Weight written on the transfer edge is not captured until the next one.
        gen_frame(0);
        send_range(0, 63);
        tick();
        bus.wgt_valid   = 1'b1;
        bus.wgt_data    = 2'd3;
        bus.frame_ready = 1'b1;
        tick();
        bus.wgt_valid = 1'b0;
        check("wx_filter_old", bus.filter,      18'h13939);
        check("wx_img",        bus.img,         IMG_MODE0);
        check("wx_count",      bus.frame_count, 3);
        gen_frame(1);
        send_range(0, 63);
        tick();
        check("wx_filter_new", bus.filter,      18'h1393B);
        check("wx_img2",       bus.img,         IMG_MODE1);
        check("wx_count2",     bus.frame_count, 4);
        check("wx_valid2",     bus.frame_valid, 1);

        // Back-to-back frames with downstream always ready.
        gen_frame(2);
        exp_a = model_img();
        send_range(0, 63);
        gen_frame(2);
        stalls = 0;
        send_range(0, 0);
        check("b2b_stall_cycles", 128'(stalls), 1);
        check("b2b_img_a",        bus.img,      exp_a);
        check("b2b_count_a",      bus.frame_count, 5);
        send_range(1, 63);
        tick();
        check("b2b_img_b",   bus.img,         model_img());
        check("b2b_count_b", bus.frame_count, 6);
        check("b2b_valid_b", bus.frame_valid, 1);

        // Reset in the middle of a frame and a weight set.
        gen_frame(2);
        send_range(0, 29);
        load_weight(2'd2); load_weight(2'd2); load_weight(2'd2); load_weight(2'd2);
        rst_n = 1'b0;
        #1;
        check("mrst_pix_ready",   bus.pix_ready,   1);
        check("mrst_wgt_ready",   bus.wgt_ready,   1);
        check("mrst_frame_valid", bus.frame_valid, 0);
        check("mrst_img",         bus.img,         0);
        check("mrst_filter",      bus.filter,      0);
        check("mrst_frame_count", bus.frame_count, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        load_weight(2'd3); load_weight(2'd1); load_weight(2'd0);
        load_weight(2'd0); load_weight(2'd0); load_weight(2'd0);
        load_weight(2'd0); load_weight(2'd0); load_weight(2'd2);
        gen_frame(1);
        send_range(0, 33);
        check("mrst_no_early_full",  bus.pix_ready,   1);
        check("mrst_no_early_valid", bus.frame_valid, 0);
        send_range(34, 63);
        tick();
        check("mrst_img_new",    bus.img,         IMG_MODE1);
        check("mrst_filter_new", bus.filter,      18'h20007);
        check("mrst_count",      bus.frame_count, 1);
        check("mrst_valid",      bus.frame_valid, 1);

        // Counter wrap over 255 more frames; the last few with input gaps.
        for (int f = 0; f < 255; f++) begin
            gap_en = (f >= 250);
            gen_frame(2);
            send_range(0, 63);
            tick();
            check("wrap_img", bus.img, model_img());
            if (f == 253) check("wrap_count_255", bus.frame_count, 255);
        end
        gap_en = 1'b0;
        check("wrap_count_0", bus.frame_count, 0);
        check("wrap_valid",   bus.frame_valid, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
